// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract controller.
//
// Time-shares one combinational full-adder cell across a WIDTH-bit operation,
// LSB first, one bit per clock, with the inter-bit carry kept in a flip-flop.
// Latency from accepted start to done is WIDTH+1 cycles; throughput is one
// operation per WIDTH+2 cycles.
//
// Ports:
//   clk    - clock, rising edge active
//   rst    - synchronous active-high reset
//   start  - request, sampled only in IDLE
//   sub    - 0: A+B+cin, 1: A-B (captured with start)
//   cin    - carry-in for add, ignored for subtract
//   A, B   - operands (captured with start)
//   busy   - high while bits are being processed
//   done   - one-cycle pulse when sum/cout/ovf have just been updated
//   sum    - result, held until the next completion
//   cout   - carry-out (for subtract: 1 = no borrow)
//   ovf    - signed two's-complement overflow
//
// state | meaning
// IDLE  | waiting for start, operands not yet captured
// RUN   | one bit per cycle through the full-adder cell
// DONE  | result registers just updated, done pulse

module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  full_adder_cell u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt == LAST);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // subtract is A + ~B + 1
            op_a  <= A;
            op_b  <= sub ? ~B : B;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          op_a  <= {1'b0, op_a[WIDTH-1:1]};
          op_b  <= {1'b0, op_b[WIDTH-1:1]};
          res   <= {fa_s, res[WIDTH-1:1]};
          carry <= fa_co;
          cnt   <= cnt + 1'b1;
          if (last_bit) begin
            sum  <= {fa_s, res[WIDTH-1:1]};
            cout <= fa_co;
            // carry is still the MSB carry-in on this edge
            ovf  <= carry ^ fa_co;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  logic clk;
  logic rst;

  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;

  logic       start2, sub2, cin2;
  logic [1:0] a2, b2;
  logic       busy2, done2, cout2, ovf2;
  logic [1:0] sum2;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .cin(cin8),
    .A(a8), .B(b8), .busy(busy8), .done(done8), .sum(sum8),
    .cout(cout8), .ovf(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .sub(sub2), .cin(cin2),
    .A(a2), .B(b2), .busy(busy2), .done(done2), .sum(sum2),
    .cout(cout2), .ovf(ovf2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference: full-width add of A and (sub ? ~B : B) with carry-in
  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic c,
                       output logic [31:0] es, output logic ec, output logic eo);
    logic [32:0] full;
    logic [31:0] mask, bb;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    bb   = (s ? ~b : b) & mask;
    full = {1'b0, a & mask} + {1'b0, bb} + {32'd0, (s ? 1'b1 : c)};
    es   = full[31:0] & mask;
    ec   = full[w];
    eo   = (a[w-1] == bb[w-1]) && (es[w-1] != a[w-1]);
  endtask

  // one WIDTH=8 operation: latency, busy span, results, return to IDLE
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic s, input logic c,
                     input logic [7:0] es, input logic ec, input logic eo);
    int lat, bc;
    a8 = a; b8 = b; sub8 = s; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); sub8 = ~s; cin8 = ~c;
    lat = 1; bc = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bc++;
      tick();
      lat++;
    end
    check({tag, "_lat"},  lat, 9);
    check({tag, "_busy"}, bc, 8);
    check({tag, "_sum"},  sum8, es);
    check({tag, "_cout"}, cout8, ec);
    check({tag, "_ovf"},  ovf8, eo);
    check({tag, "_bd"},   busy8, 0);
    tick();
    check({tag, "_idle"}, {busy8, done8}, 0);
  endtask

  initial begin
    logic [31:0] es;
    logic        ec, eo;
    int          lat, dcnt, gap;
    logic [7:0]  ra, rb;
    logic [1:0]  qa, qb;
    logic        rs, rc;

    rst = 1'b1;
    start8 = 0; sub8 = 0; cin8 = 0; a8 = 0; b8 = 0;
    start2 = 0; sub2 = 0; cin2 = 0; a2 = 0; b2 = 0;
    tick(); tick();
    rst = 1'b0;
    check("reset_outs", {busy8, done8, sum8, cout8, ovf8}, 0);
    check("reset_outs2", {busy2, done2, sum2, cout2, ovf2}, 0);

    op8("add_5a_3c",  8'h5A, 8'h3C, 0, 0, 8'h96, 0, 1);
    op8("add_ff_01",  8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);
    op8("add_ff_01c", 8'hFF, 8'h01, 0, 1, 8'h01, 1, 0);
    op8("sub_10_20",  8'h10, 8'h20, 1, 0, 8'hF0, 0, 0);
    op8("sub_80_01",  8'h80, 8'h01, 1, 0, 8'h7F, 1, 1);
    op8("sub_cin_ign", 8'h05, 8'h03, 1, 1, 8'h02, 1, 0);

    // handshake: re-pulses at k+3 and k+9 are ignored
    a8 = 8'h5A; b8 = 8'h3C; sub8 = 0; cin8 = 0; start8 = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      start8 = (c == 3 || c == 9);
      a8 = 8'h11; b8 = 8'h22; sub8 = 1'b1;
      check($sformatf("hs_busy_k%0d", c), busy8, (c <= 8));
      check($sformatf("hs_done_k%0d", c), done8, (c == 9));
      if (c == 5) check("hs_sum_hold", sum8, 8'h02);
    end
    check("hs_sum", sum8, 8'h96);
    tick();
    start8 = 1'b0;
    check("hs_k10_idle", {busy8, done8}, 0);
    check("hs_k10_sum", sum8, 8'h96);
    op8("hs_k10_accept", 8'hFF, 8'h01, 0, 0, 8'h00, 1, 0);

    // reset mid-operation
    op8("pre_rst", 8'h5A, 8'h3C, 0, 0, 8'h96, 0, 1);
    a8 = 8'h01; b8 = 8'h01; sub8 = 0; cin8 = 0; start8 = 1'b1;
    tick(); start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_outs", {busy8, done8, sum8, cout8, ovf8}, 0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) dcnt++;
      tick();
    end
    check("rst_no_done", dcnt, 0);
    op8("post_rst", 8'h20, 8'h22, 0, 1, 8'h43, 0, 0);

    // reset and start together: reset wins
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; start8 = 1'b0;
    check("rst_start_busy", busy8, 0);
    tick();
    check("rst_start_busy2", busy8, 0);

    // random regression, WIDTH=8
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      model(8, {24'd0, ra}, {24'd0, rb}, rs, rc, es, ec, eo);
      a8 = ra; b8 = rb; sub8 = rs; cin8 = rc; start8 = 1'b1;
      tick();
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 1;
      while (!done8 && lat < 40) begin tick(); lat++; end
      check("r8_lat", lat, 9);
      check("r8_res", {sum8, cout8, ovf8}, {es[7:0], ec, eo});
      tick();
    end

    // random regression, WIDTH=2
    for (int n = 0; n < 1000; n++) begin
      qa = 2'($urandom); qb = 2'($urandom); rs = 1'($urandom); rc = 1'($urandom);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      model(2, {30'd0, qa}, {30'd0, qb}, rs, rc, es, ec, eo);
      a2 = qa; b2 = qb; sub2 = rs; cin2 = rc; start2 = 1'b1;
      tick();
      start2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
      lat = 1;
      while (!done2 && lat < 40) begin tick(); lat++; end
      check("r2_lat", lat, 3);
      check("r2_res", {sum2, cout2, ovf2}, {es[1:0], ec, eo});
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder/subtractor controller that time-shares a single one-bit full-adder cell across a WIDTH-bit operation. It sequences the cell LSB-first, one bit per clock, and keeps the inter-bit carry in a flip-flop. A start/busy/done handshake lets a requester hand over two operands and collect a WIDTH-bit result, carry-out and signed overflow after a fixed latency. This is the sequencing layer above the team's combinational full-adder cell, which the block instantiates internally.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = A+B+cin, 1 = A−B (captured with start).
- cin  input  1  carry-in for add; ignored when sub=1.
- A  input  WIDTH  operand A (captured with start).
- B  input  WIDTH  operand B (captured with start).
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: result registers just updated.
- sum  output  WIDTH  result, held until next completion.
- cout  output  1  carry-out (sub: 1 = no borrow).
- ovf  output  1  signed two's-complement overflow.

## Operation
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- States: IDLE, RUN, DONE. Bit counter is $clog2(WIDTH) bits wide.
- IDLE → RUN when start=1:
  - Capture A into opA.
  - Capture B into opB; when sub=1, capture ~B instead.
  - Carry FF ← (sub ? 1 : cin).
  - Counter ← 0.
- RUN, each cycle:
  - Feed opA[0], opB[0] and carry FF to the full-adder cell.
  - Shift the cell's sum bit into the MSB of the shift result register.
  - Shift opA and opB right by one.
  - Carry FF ← cell carry.
  - Counter increments.
  - When counter = WIDTH−1, also save the cell carry-in as the MSB carry-in (for ovf). On that edge go to DONE.
- On the RUN → DONE edge:
  - sum ← final shifted result.
  - cout ← final carry.
  - ovf ← MSB carry-in XOR final carry.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- start is ignored in RUN and DONE; it is not queued.
- sum, cout and ovf change only on the RUN → DONE edge. They are stable at all other times, including throughout the next operation's RUN.
- Reset while rst=1, regardless of state:
  - State ← IDLE.
  - busy, done, sum, cout, ovf ← 0.
  - Internal registers are cleared.
  - An in-flight operation is aborted and produces no done.
- rst and start high in the same cycle: reset wins; start is not accepted.

## Timing
- start sampled high in IDLE at cycle k:
  - busy=1 in cycles k+1 … k+WIDTH.
  - done=1 and new sum/cout/ovf visible in cycle k+WIDTH+1.
- Back-to-back: the earliest next acceptance is cycle k+WIDTH+2, in IDLE. The throughput is one operation per WIDTH+2 cycles.
- busy and done are never high together. busy=0 and done=0 in IDLE.
- Reset values: busy=0, done=0, sum=0, cout=0, ovf=0. The first cycle after rst falls is in IDLE.
- Inputs A, B, sub and cin may change freely after the capture cycle without affecting the result.

## Test plan
- WIDTH=8, A=0x5A, B=0x3C, sub=0, cin=0 → done at k+9 with sum=0x96, cout=0, ovf=1.
- A=0xFF, B=0x01, sub=0, cin=0 → sum=0x00, cout=1, ovf=0; the same operands with cin=1 → sum=0x01, cout=1, ovf=0.
- sub=1, A=0x10, B=0x20 → sum=0xF0, cout=0, ovf=0; then sub=1, A=0x80, B=0x01 → sum=0x7F, cout=1, ovf=1.
- Handshake timing:
  - Stimulus: pulse start at k; re-pulse start at k+3 and at k+9 (DONE) with different operands.
  - Required: the re-pulses are ignored; a single done at k+9 carries the first result; busy covers exactly k+1..k+8.
  - Then start at k+10 is accepted.
- Reset mid-operation:
  - Stimulus: complete one add (sum=0x96), start another, assert rst at k+4 for one cycle.
  - Required: next cycle busy=0, done=0, sum=0, cout=0, ovf=0; no done follows.
  - A fresh start then completes normally.
- Random regression: 1000 random A, B, sub, cin with random start gaps, at WIDTH=8 and WIDTH=2.
  - Required: sum/cout/ovf match a reference model of the full-width add/subtract.
  - Required: done latency is always WIDTH+1.
